spi_reg_bridge: RTL
===================

# spi_reg_bridge

Command/register bridge directly downstream of the ball detector's SPI slave. Consumes the byte stream received over SPI, decodes a one-byte command header (read/write flag plus start address), and turns the frame into single-cycle register-bus writes or reads toward the detector's configuration/status registers. Read data is handed back to the SPI slave as the byte to shift out on the next transfer. Supports auto-incrementing bursts within one chip-select frame.

## Interface
- ADDR_W, 7, register address width, 1..7; taken from cmd byte bits [ADDR_W-1:0]
- AUTO_INC, 1, 1 = address increments after each data byte, 0 = address fixed for whole frame
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- cs  in  1  SPI chip select, active low, already synchronous to clk
- rx_data  in  8  byte received by SPI slave
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to be shifted out on next SPI transfer
- tx_load  out  1  one-cycle strobe, SPI slave latches tx_data
- reg_addr  out  ADDR_W  register address
- reg_wdata  out  8  write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid the cycle after reg_re
- busy  out  1  high while a frame is active (state != IDLE)
- err  out  1  sticky overrun flag

## Operation
- Reset (rst_n low at a clk edge): state IDLE; tx_data 0x00, tx_load 0, reg_addr 0, reg_wdata 0x00, reg_we 0, reg_re 0, busy 0, err 0. All outputs registered.
- States: IDLE, CMD, WR, RD_FETCH, RD_WAIT, RD_HOLD.
- IDLE: cs low -> CMD; same edge pulses tx_load with tx_data = STATUS = {err, 7'h01}.
- CMD: on rx_valid: addr <= rx_data[ADDR_W-1:0]; rx_data[7]=0 -> WR, rx_data[7]=1 -> RD_FETCH. Bits [6:ADDR_W] ignored.
- WR: each rx_valid -> reg_we=1, reg_addr=addr, reg_wdata=rx_data for one cycle; then addr <= addr+AUTO_INC, modulo 2^ADDR_W. Stay in WR.
- RD_FETCH: reg_re=1 with reg_addr=addr for one cycle -> RD_WAIT.
- RD_WAIT: sample reg_rdata; tx_data <= reg_rdata, tx_load=1; addr <= addr+AUTO_INC -> RD_HOLD.
- RD_HOLD: rx_valid (dummy byte clocked in, loaded byte shifted out) -> RD_FETCH. rx_data discarded.
- rx_valid in RD_FETCH or RD_WAIT: overrun; err <= 1, byte discarded, state sequence continues unchanged.
- cs high in any non-IDLE state -> IDLE next edge; busy drops. An rx_valid in that same cycle is still processed (write issued / address latched) before returning to IDLE; no read fetch is started.
- err cleared only by reset.
- Address wrap: addr 2^ADDR_W-1 +1 -> 0; no error.

## Timing
- Write: rx_valid at cycle T -> reg_we high in T+1 only.
- Read: header rx_valid at T -> reg_re in T+1 -> reg_rdata sampled at end of T+2 -> tx_load/tx_data visible T+3. Next fetch: dummy rx_valid at U -> tx_load at U+3.
- Frame start: cs low seen at T -> tx_load (STATUS) in T+1.
- rx_valid spacing of at least 4 clk cycles required for overrun-free reads (guaranteed by clk >= 1 SPI clock x 0.5 ratio).
- reg_we, reg_re, tx_load never high for more than one consecutive cycle; reg_we and reg_re never high together.
- Reset mid-frame: IDLE on next edge; if cs still low after release, new frame begins (STATUS reload), next byte treated as command.

## Test plan
- Write burst: cs low, bytes 0x05,0xAA,0xBB, cs high -> reg_we pulses at addr 5 data 0xAA, addr 6 data 0xBB, each 1 cycle after rx_valid; busy low after cs high.
- Read burst: reg file addr 0x10=0x3C, 0x11=0xC3; bytes 0x90,0x00,0x00 -> reg_re at 0x10, tx_load 0x3C 3 cycles after header; reg_re at 0x11, tx_load 0xC3 3 cycles after first dummy.
- Wrap: write header 0x7F then 2 data bytes -> writes at addr 0x7F then 0x00; AUTO_INC=0 -> both at 0x7F.
- Overrun: read header, second rx_valid 1 cycle later -> err=1, byte dropped, next frame STATUS tx_data = 0x81.
- Abort: cs high between header 0x02 and data -> no reg_we; next frame header 0x03 data 0x11 -> single write addr 3 data 0x11.
- Reset mid-read with cs low -> all outputs to reset values, err 0; after release, tx_load STATUS 0x01 and next byte decoded as command.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// spi_reg_bridge
//
// Purpose:
//   Sits behind the ball detector's SPI slave. The first byte of every
//   chip-select frame is a command header {rw, addr}; rw=0 turns every
//   following byte into a single-cycle register write, rw=1 turns the frame
//   into a stream of register reads whose data is handed back to the SPI
//   slave for shifting out on the next transfer. The address optionally
//   auto-increments (modulo 2^ADDR_W) after every data byte.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   cs         SPI chip select, active low, already in the clk domain
//   rx_data    byte received by the SPI slave
//   rx_valid   one-cycle strobe qualifying rx_data
//   tx_data    byte for the SPI slave to shift out next
//   tx_load    one-cycle strobe, SPI slave latches tx_data
//   reg_addr   register bus address
//   reg_wdata  register bus write data
//   reg_we     one-cycle register write strobe
//   reg_re     one-cycle register read strobe
//   reg_rdata  register read data, valid the cycle after reg_re
//   busy       high while a frame is being handled
//   err        sticky overrun flag, cleared only by reset
// -----------------------------------------------------------------------------

// Protocol properties of the bridge outputs, kept apart from the datapath.
module spi_reg_bridge_checker (
    input logic clk,
    input logic rst_n,
    input logic tx_load,
    input logic reg_we,
    input logic reg_re,
    input logic err
);
    // Reads and writes are never issued in the same cycle.
    a_we_re_excl : assert property (@(posedge clk) !(reg_we && reg_re));

    // A read strobe is always followed by at least one idle cycle.
    a_re_pulse   : assert property (@(posedge clk) reg_re |=> !reg_re);

    // The SPI slave is never asked to load two bytes back to back.
    a_ld_pulse   : assert property (@(posedge clk) tx_load |=> !tx_load);

    // Once raised, the overrun flag only falls through reset.
    a_err_sticky : assert property (@(posedge clk) (err && rst_n) |=> err);
endmodule

module spi_reg_bridge #(
    parameter int ADDR_W   = 7,
    parameter int AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_load,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_WR       = 3'd2,
        ST_RD_FETCH = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RD_HOLD  = 3'd5
    } state_t;

    // Address step applied after each data byte; zero keeps the frame on
    // a single register.
    localparam logic [ADDR_W-1:0] ADDR_STEP = (AUTO_INC != 0) ? ADDR_W'(1) : ADDR_W'(0);

    // Byte presented to the SPI master at the start of every frame.
    function automatic logic [7:0] status_byte(input logic err_flag);
        return {err_flag, 7'h01};
    endfunction

    // Next burst address; wraps naturally at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] addr_advance(input logic [ADDR_W-1:0] a);
        return a + ADDR_STEP;
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   addr_s;
    logic [7:0]          tx_data_s;
    logic                tx_load_s;
    logic [ADDR_W-1:0]   reg_addr_s;
    logic [7:0]          reg_wdata_s;
    logic                reg_we_s;
    logic                reg_re_s;
    logic                err_s;

    // Next-state and next-output logic. Strobes are computed on the edge that
    // enters their state so that, once registered, a write lands one cycle
    // after its rx_valid and a read fetch one cycle after its trigger byte.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        tx_data_s   = tx_data;
        tx_load_s   = 1'b0;
        reg_addr_s  = reg_addr;
        reg_wdata_s = reg_wdata;
        reg_we_s    = 1'b0;
        reg_re_s    = 1'b0;
        err_s       = err;

        case (state_r)
            ST_IDLE: begin
                if (!cs) begin
                    state_s   = ST_CMD;
                    tx_load_s = 1'b1;
                    tx_data_s = status_byte(err);
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_CMD: begin
                if (rx_valid) begin
                    addr_s = rx_data[ADDR_W-1:0];
                end else begin
                    addr_s = addr_r;
                end
                if (cs) begin
                    // Header latched above but the frame is over: no fetch.
                    state_s = ST_IDLE;
                end else if (rx_valid && rx_data[7]) begin
                    state_s    = ST_RD_FETCH;
                    reg_re_s   = 1'b1;
                    reg_addr_s = rx_data[ADDR_W-1:0];
                end else if (rx_valid) begin
                    state_s = ST_WR;
                end else begin
                    state_s = ST_CMD;
                end
            end

            ST_WR: begin
                // A byte arriving together with cs rising is still written.
                if (rx_valid) begin
                    reg_we_s    = 1'b1;
                    reg_addr_s  = addr_r;
                    reg_wdata_s = rx_data;
                    addr_s      = addr_advance(addr_r);
                end else begin
                    addr_s = addr_r;
                end
                if (cs) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WR;
                end
            end

            ST_RD_FETCH: begin
                // The read strobe is already on the bus this cycle; a byte
                // arriving now cannot be answered in time.
                if (rx_valid) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err;
                end
                if (cs) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                if (rx_valid) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err;
                end
                if (cs) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s   = ST_RD_HOLD;
                    tx_data_s = reg_rdata;
                    tx_load_s = 1'b1;
                    addr_s    = addr_advance(addr_r);
                end
            end

            ST_RD_HOLD: begin
                // The dummy byte's content is irrelevant; its arrival means
                // the loaded byte has gone out and the next one is wanted.
                if (cs) begin
                    state_s = ST_IDLE;
                end else if (rx_valid) begin
                    state_s    = ST_RD_FETCH;
                    reg_re_s   = 1'b1;
                    reg_addr_s = addr_r;
                end else begin
                    state_s = ST_RD_HOLD;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, burst address and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            addr_r    <= {ADDR_W{1'b0}};
            tx_data   <= 8'h00;
            tx_load   <= 1'b0;
            reg_addr  <= {ADDR_W{1'b0}};
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            tx_data   <= tx_data_s;
            tx_load   <= tx_load_s;
            reg_addr  <= reg_addr_s;
            reg_wdata <= reg_wdata_s;
            reg_we    <= reg_we_s;
            reg_re    <= reg_re_s;
            busy      <= (state_s != ST_IDLE);
            err       <= err_s;
        end
    end

    spi_reg_bridge_checker u_checker (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_load (tx_load),
        .reg_we  (reg_we),
        .reg_re  (reg_re),
        .err     (err)
    );

endmodule
